// File: rtl/bram_pkg.sv
// bram_pkg: shared types and default geometry for the dual-port RAM
package bram_pkg;
  typedef enum logic {INIT, RUN} state_t;
  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 8;
  localparam int DEPTH = 2 ** ADDR_W_DEF;
  localparam int NBYTES = DATA_W_DEF / 8;
endpackage

// File: rtl/bram_out_stage.sv
// bram_out_stage: read-data/valid stage 1 plus optional second register stage
module bram_out_stage #(
  parameter int W = 32,
  parameter bit OUT_REG = 0
) (
  input  logic         CLK,
  input  logic         RSTN,
  input  logic         ld,
  input  logic [W-1:0] din,
  output logic [W-1:0] DO,
  output logic         VLD
);
  logic [W-1:0] d1;
  logic v1;
  always_ff @(posedge CLK or negedge RSTN)
    if (!RSTN) begin
      d1 <= '0;
      v1 <= 1'b0;
    end else begin
      d1 <= ld ? din : '0;
      v1 <= ld;
    end
  generate
    if (OUT_REG) begin : g_reg
      logic [W-1:0] d2;
      logic v2;
      always_ff @(posedge CLK or negedge RSTN)
        if (!RSTN) begin
          d2 <= '0;
          v2 <= 1'b0;
        end else begin
          d2 <= d1;
          v2 <= v1;
        end
      assign DO = d2;
      assign VLD = v2;
    end else begin : g_dir
      assign DO = d1;
      assign VLD = v1;
    end
  endgenerate
endmodule

// File: rtl/bram_dp_init.sv
// bram_dp_init: true dual-port byte-writable RAM with hardware zero-fill engine
module bram_dp_init
  import bram_pkg::*;
#(
  parameter int DATA_W = NBYTES * 8,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter bit OUT_REG = 0,
  parameter bit RDW_MODE = 0,
  parameter bit INIT_ON_RST = 1
) (
  input  logic                CLK,
  input  logic                RSTN,
  input  logic                CLR,
  output logic                READY,
  input  logic                EN_A,
  input  logic [DATA_W/8-1:0] WE_A,
  input  logic [31:0]         ADDR_A,
  input  logic [DATA_W-1:0]   DI_A,
  output logic [DATA_W-1:0]   DO_A,
  output logic                VLD_A,
  input  logic                EN_B,
  input  logic [DATA_W/8-1:0] WE_B,
  input  logic [31:0]         ADDR_B,
  input  logic [DATA_W-1:0]   DI_B,
  output logic [DATA_W-1:0]   DO_B,
  output logic                VLD_B
);
  localparam int NB = DATA_W / 8;
  state_t state;
  logic [ADDR_W-1:0] cnt, wa, wb;
  logic acc_a, acc_b;
  logic [DATA_W-1:0] old_a, old_b, rd_a, rd_b;
  logic unused_hi;
  (* ram_style = "block" *) logic [DATA_W-1:0] mem [2**ADDR_W];
  assign unused_hi = ^{ADDR_A[31:ADDR_W], ADDR_B[31:ADDR_W]};
  assign wa = ADDR_A[ADDR_W-1:0];
  assign wb = ADDR_B[ADDR_W-1:0];
  assign acc_a = READY & EN_A;
  assign acc_b = READY & EN_B;
  assign old_a = mem[wa];
  assign old_b = mem[wb];
  // write-first only merges the port's own lanes; the other port always sees the old word
  always_comb begin
    rd_a = old_a;
    rd_b = old_b;
    for (int i = 0; i < NB; i++) begin
      if (RDW_MODE && WE_A[i]) rd_a[8*i+:8] = DI_A[8*i+:8];
      if (RDW_MODE && WE_B[i]) rd_b[8*i+:8] = DI_B[8*i+:8];
    end
  end
  always_ff @(posedge CLK or negedge RSTN)
    if (!RSTN) begin
      state <= INIT_ON_RST ? INIT : RUN;
      cnt <= '0;
      READY <= !INIT_ON_RST;
    end else if (state == INIT) begin
      cnt <= cnt + 1'b1;
      if (&cnt) begin
        state <= RUN;
        READY <= 1'b1;
      end
    end else if (CLR) begin
      state <= INIT;
      cnt <= '0;
      READY <= 1'b0;
    end
  // port A is applied last so it wins lanes written by both ports
  always_ff @(posedge CLK)
    if (RSTN) begin
      if (state == INIT) mem[cnt] <= '0;
      else
        for (int i = 0; i < NB; i++) begin
          if (acc_b && WE_B[i]) mem[wb][8*i+:8] <= DI_B[8*i+:8];
          if (acc_a && WE_A[i]) mem[wa][8*i+:8] <= DI_A[8*i+:8];
        end
    end
  bram_out_stage #(.W(DATA_W), .OUT_REG(OUT_REG)) u_out_a (
    .CLK(CLK), .RSTN(RSTN), .ld(acc_a), .din(rd_a), .DO(DO_A), .VLD(VLD_A)
  );
  bram_out_stage #(.W(DATA_W), .OUT_REG(OUT_REG)) u_out_b (
    .CLK(CLK), .RSTN(RSTN), .ld(acc_b), .din(rd_b), .DO(DO_B), .VLD(VLD_B)
  );
endmodule

// File: tb/tb_bram_dp_init.sv
// tb_bram_dp_init: scoreboard bench driving two configurations with shared stimulus
module tb_bram_dp_init;
  typedef struct {int due; logic [31:0] d;} exp_t;
  logic clk = 1'b0, rstn = 1'b0, clr = 1'b0;
  logic en_a = 1'b0, en_b = 1'b0;
  logic [3:0] we_a = '0, we_b = '0;
  logic [31:0] addr_a = '0, addr_b = '0, di_a = '0, di_b = '0;
  logic r0, r1, va0, vb0, va1, vb1;
  logic [31:0] da0, db0, da1, db1;
  logic [32:0] obs [4];
  logic [31:0] mem_m [256];
  exp_t q [4][$];
  string names [4] = '{"a_lat1_rf", "b_lat1_rf", "a_lat2_wf", "b_lat2_wf"};
  int cyc = 0, n_chk = 0, n_fail = 0, m_fill = 0, n;
  logic m_ready = 1'b0;

  always #5 clk = ~clk;

  bram_dp_init #(.DATA_W(32), .ADDR_W(8), .OUT_REG(0), .RDW_MODE(0), .INIT_ON_RST(1)) u0 (
    .CLK(clk), .RSTN(rstn), .CLR(clr), .READY(r0),
    .EN_A(en_a), .WE_A(we_a), .ADDR_A(addr_a), .DI_A(di_a), .DO_A(da0), .VLD_A(va0),
    .EN_B(en_b), .WE_B(we_b), .ADDR_B(addr_b), .DI_B(di_b), .DO_B(db0), .VLD_B(vb0)
  );
  bram_dp_init #(.DATA_W(32), .ADDR_W(8), .OUT_REG(1), .RDW_MODE(1), .INIT_ON_RST(1)) u1 (
    .CLK(clk), .RSTN(rstn), .CLR(clr), .READY(r1),
    .EN_A(en_a), .WE_A(we_a), .ADDR_A(addr_a), .DI_A(di_a), .DO_A(da1), .VLD_A(va1),
    .EN_B(en_b), .WE_B(we_b), .ADDR_B(addr_b), .DI_B(di_b), .DO_B(db1), .VLD_B(vb1)
  );
  assign obs[0] = {va0, da0};
  assign obs[1] = {vb0, db0};
  assign obs[2] = {va1, da1};
  assign obs[3] = {vb1, db1};

  task automatic check(input string tag, input logic [32:0] o, input logic [32:0] e);
    n_chk++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, o, e);
    end
  endtask

  function automatic logic [31:0] mrg(input logic [31:0] o, input logic [31:0] d, input logic [3:0] w);
    mrg = o;
    for (int i = 0; i < 4; i++) if (w[i]) mrg[8*i+:8] = d[8*i+:8];
  endfunction

  always @(negedge clk) begin
    logic [32:0] e;
    check("ready_u0", {32'h0, r0}, {32'h0, m_ready});
    check("ready_u1", {32'h0, r1}, {32'h0, m_ready});
    for (int s = 0; s < 4; s++) begin
      e = '0;
      if (q[s].size() > 0 && q[s][0].due == cyc) begin
        e = {1'b1, q[s][0].d};
        void'(q[s].pop_front());
      end
      check(names[s], obs[s], e);
    end
  end

  // one clock: book expectations from the model, then advance past the edge
  task automatic step();
    logic [7:0] ia, ib;
    logic [31:0] oa, ob;
    if (rstn && m_ready) begin
      ia = addr_a[7:0];
      ib = addr_b[7:0];
      oa = mem_m[ia];
      ob = mem_m[ib];
      if (en_a) begin
        q[0].push_back('{cyc + 1, oa});
        q[2].push_back('{cyc + 2, mrg(oa, di_a, we_a)});
      end
      if (en_b) begin
        q[1].push_back('{cyc + 1, ob});
        q[3].push_back('{cyc + 2, mrg(ob, di_b, we_b)});
      end
      if (en_b) mem_m[ib] = mrg(mem_m[ib], di_b, we_b);
      if (en_a) mem_m[ia] = mrg(mem_m[ia], di_a, we_a);
      if (clr) begin
        m_ready = 1'b0;
        m_fill = 0;
      end
    end else if (rstn) begin
      m_fill++;
      if (m_fill == 256) begin
        m_ready = 1'b1;
        foreach (mem_m[i]) mem_m[i] = '0;
      end
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
    #2;
  endtask

  task automatic idle();
    en_a = 1'b0; en_b = 1'b0; we_a = '0; we_b = '0; clr = 1'b0;
  endtask

  task automatic wr_a(input logic [31:0] a, input logic [31:0] d, input logic [3:0] w);
    en_a = 1'b1; addr_a = a; di_a = d; we_a = w;
  endtask

  task automatic wr_b(input logic [31:0] a, input logic [31:0] d, input logic [3:0] w);
    en_b = 1'b1; addr_b = a; di_b = d; we_b = w;
  endtask

  task automatic assert_rst();
    rstn = 1'b0;
    m_ready = 1'b0;
    m_fill = 0;
    for (int s = 0; s < 4; s++) q[s].delete();
    #1;
    check("rst_ready", {31'h0, r0, r1}, 33'h0);
    for (int s = 0; s < 4; s++) check("rst_out", obs[s], 33'h0);
  endtask

  task automatic wait_fill(input string tag);
    n = 0;
    while (!r0 && n < 400) begin
      step();
      n++;
    end
    check(tag, 33'(n), 33'd256);
  endtask

  initial begin
    idle();
    repeat (3) step();
    rstn = 1'b1;
    wait_fill("fill_len_por");
    // reads straight after fill return zero
    wr_a(32'h55, 32'h0, 4'h0); wr_b(32'hC3, 32'h0, 4'h0); step();
    idle(); step(); step();
    // partial-byte write, read back from B
    wr_a(32'h10, 32'h11223344, 4'hF); step();
    wr_a(32'h10, 32'hDEADBEEF, 4'b0101); step();
    idle(); wr_b(32'h10, 32'h0, 4'h0); step();
    idle(); step(); step();
    // address aliasing above ADDR_W
    wr_a(32'h1000_0040, 32'h12345678, 4'hF); step();
    idle(); wr_b(32'h40, 32'h0, 4'h0); step();
    idle(); step(); step();
    // write/write collision
    wr_a(32'h20, 32'hAAAAAAAA, 4'b0011); wr_b(32'h20, 32'hBBBBBBBB, 4'b0110); step();
    idle(); wr_b(32'h20, 32'h0, 4'h0); step();
    idle(); step(); step();
    // read-during-write, same and cross port
    wr_a(32'h30, 32'h7, 4'hF); step();
    wr_a(32'h30, 32'h5, 4'hF); wr_b(32'h30, 32'h0, 4'h0); step();
    idle(); wr_b(32'h30, 32'h0, 4'h0); step();
    idle(); step(); step();
    // random traffic over a small window to provoke collisions
    for (int k = 0; k < 40; k++) begin
      en_a = 1'($urandom_range(0, 1)); we_a = 4'($urandom);
      addr_a = ($urandom & 32'hFFFF_FF00) | 32'($urandom_range(0, 7)); di_a = $urandom;
      en_b = 1'($urandom_range(0, 1)); we_b = 4'($urandom);
      addr_b = ($urandom & 32'hFFFF_FF00) | 32'($urandom_range(0, 7)); di_b = $urandom;
      step();
    end
    idle(); step(); step();
    // clear request; writes during fill are dropped, CLR mid-fill ignored
    clr = 1'b1; step();
    idle();
    wr_a(32'h10, 32'hFFFFFFFF, 4'hF);
    repeat (5) step();
    idle(); clr = 1'b1; step();
    idle();
    n = 0;
    while (!r0 && n < 400) begin
      step();
      n++;
    end
    check("fill_len_clr", 33'(n), 33'd250);
    wr_a(32'h10, 32'h0, 4'h0); wr_b(32'h20, 32'h0, 4'h0); step();
    idle(); step(); step();
    // reset mid-fill restarts the fill
    clr = 1'b1; step();
    idle();
    repeat (100) step();
    assert_rst();
    step(); step();
    rstn = 1'b1;
    wait_fill("fill_len_abort");
    // reset while read data is on the outputs
    wr_a(32'h0, 32'hCAFEF00D, 4'hF); step();
    idle(); wr_a(32'h0, 32'h0, 4'h0); wr_b(32'h0, 32'h0, 4'h0); step();
    idle();
    check("pre_rst_vld", {va0, da0}, {1'b1, 32'hCAFEF00D});
    assert_rst();
    step();
    rstn = 1'b1;
    wait_fill("fill_len_rst2");
    wr_a(32'h0, 32'h0, 4'h0); wr_b(32'h10, 32'h0, 4'h0); step();
    idle(); repeat (3) step();
    check("drain", 33'(q[0].size() + q[1].size() + q[2].size() + q[3].size()), 33'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
